key_frame_rx: RTL and testbench
===============================

# key_frame_rx

PS/2-style keyboard frame receiver and sequencer, clocked by sysClk. Samples the raw keyboard clock and data lines and detects keyClk falling edges. Steps an FSM through start, 8 data, parity and stop bits, then hands each good scan code to the downstream decoder over a valid/ready register. Frame, parity, timeout and overrun faults are reported as single-cycle error pulses.

## Interface
- TIMEOUT_CYCLES, default 50000: max sysClk cycles between keyClk falls inside a frame (2 ms at 25 MHz).
- sysClk  in  1  system clock; all state on posedge.
- reset  in  1  synchronous, active-high; clock sysClk.
- keyClk  in  1  raw keyboard clock, asynchronous, idles high.
- keyData  in  1  raw keyboard data, asynchronous, idles high.
- code  out  8  received scan code; stable while codeValid=1.
- codeValid  out  1  code holds an unconsumed byte.
- codeReady  in  1  consumer accepts code when codeValid & codeReady.
- parityErr  out  1  one-cycle pulse: odd-parity check failed.
- frameErr  out  1  one-cycle pulse: bad start/stop bit or timeout.
- overrun  out  1  one-cycle pulse: good byte dropped, output still full.
- busy  out  1  FSM not in IDLE.

## Operation
- keyClk and keyData each pass through 2-flop synchronizers, reset to 1. Both are delayed equally, so they stay aligned.
- fall = previous synced keyClk 1 and current 0. It is a one-cycle pulse and the only event that advances the FSM.
- IDLE: fall with data 0 goes to DATA with bitCnt=0. Fall with data 1 pulses frameErr and stays in IDLE.
- DATA: on each fall, shift the data bit into sh[7] and move sh right, so bits arrive LSB first; bitCnt++. The 8th fall goes to PARITY.
- PARITY: on fall, capture the parity bit and go to STOP.
- STOP: on fall, always return to IDLE.
  - Stop bit 0: frameErr pulse.
  - Otherwise, ^{sh,par}=0: parityErr pulse.
  - Otherwise: deliver sh.
  - Exactly one outcome per frame; frameErr has priority.
- Timeout: in DATA, PARITY or STOP, a counter clears on every fall and increments otherwise. When it reaches TIMEOUT_CYCLES-1: frameErr pulse, partial byte discarded, go to IDLE. The counter is held at 0 in IDLE.
- Counter width is $clog2(TIMEOUT_CYCLES). bitCnt is 3 bits and never wraps mid-frame.
- Delivery rules:
  - codeValid=0, or codeValid&codeReady in the same cycle: load code, codeValid=1.
  - codeValid&!codeReady: drop the new byte, pulse overrun; code and codeValid unchanged.
- codeValid&codeReady with no delivery that cycle: codeValid←0. code keeps its last value.

## Timing
- Reset values: code=0, codeValid=0, parityErr=0, frameErr=0, overrun=0, busy=0. State=IDLE, counters 0, synchronizers 1.
- Reset is synchronous and dominates all other events. Reset mid-frame discards the partial byte and clears the output register.
- Raw keyClk low first sampled at edge k: fall is high during the cycle after edge k+1. The FSM acts on edge k+2.
- codeValid and the error pulses rise at edge k+2 of the stop-bit fall. Each is registered and high for exactly one cycle (codeValid persists until accepted).
- Throughput: at most one byte per frame (≥11 keyClk periods). The output register is one entry deep.
- keyClk glitches shorter than one sysClk period are not filtered.

## Structure
- Package key_pkg holds:
  - typedef enum logic [1:0] rxState_t {IDLE, DATA, PARITY, STOP};
  - localparam FRAME_DATA_BITS = 8.
- Sub-module key_sync_edge: 2-flop synchronizer plus a registered previous value, outputting the synced level and the fall pulse. Two instances: keyClk (uses fall) and keyData (uses level).
- FSM, shift register, timeout counter and output register live in key_frame_rx.

## Test plan
- Good frame 0x1C: start 0; data 0,0,1,1,1,0,0,0; parity 0; stop 1; codeReady=0. Expect code=0x1C, codeValid=1 and holding. Assert codeReady one cycle: codeValid=0 next cycle; no error pulses.
- Parity fault: 0x1C with parity 1. Expect one parityErr pulse, codeValid stays 0, busy=0 after the stop fall.
- Stop fault: 0x1C, parity 0, stop 0. Expect one frameErr pulse only, no parityErr.
- Timeout: start plus 4 data bits, then keyClk held high for TIMEOUT_CYCLES. Expect frameErr exactly TIMEOUT_CYCLES-1 cycles after the last fall, then IDLE. Next frame 0xF0 (parity 1) gives code=0xF0.
- Overrun and simultaneous accept:
  - codeReady=0; send 0x1C then 0x32. Expect code=0x1C and one overrun pulse.
  - Then hold codeReady=1 so it coincides with delivery of 0x29. Expect code=0x29 and codeValid remains 1.
- Reset mid-frame: assert reset after 5 data bits. Expect all outputs 0 next cycle and busy=0. Next full frame 0x5A (parity 1) decodes correctly.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and constants for the keyboard frame receiver.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rxState_t;

  localparam int FRAME_DATA_BITS = 8;

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer for one raw keyboard line, plus a delayed copy
// used to flag a high-to-low transition of the synchronized level.
module key_sync_edge (
  input  logic sysClk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Lines idle high, so everything resets to 1 to avoid a false fall.
  always_ff @(posedge sysClk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/key_frame_rx.sv
// PS/2-style frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Good bytes go to a one-deep valid/ready output register.
module key_frame_rx
  import key_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       sysClk,
  input  logic       reset,
  input  logic       keyClk,
  input  logic       keyData,
  output logic [7:0] code,
  output logic       codeValid,
  input  logic       codeReady,
  output logic       parityErr,
  output logic       frameErr,
  output logic       overrun,
  output logic       busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  // Fires on the cycle the counter would step to TIMEOUT_CYCLES-1.
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 2);
  localparam logic [2:0]      LAST_BIT = 3'(FRAME_DATA_BITS - 1);

  logic fall;
  logic data_lvl;
  logic clk_lvl_unused;
  logic data_fall_unused;

  key_sync_edge u_clk_sync (
    .sysClk (sysClk),
    .reset  (reset),
    .raw_i  (keyClk),
    .level_o(clk_lvl_unused),
    .fall_o (fall)
  );

  key_sync_edge u_data_sync (
    .sysClk (sysClk),
    .reset  (reset),
    .raw_i  (keyData),
    .level_o(data_lvl),
    .fall_o (data_fall_unused)
  );

  rxState_t                       state_q, state_d;
  logic [2:0]                     bit_cnt_q, bit_cnt_d;
  logic [FRAME_DATA_BITS-1:0]     sh_q, sh_d;
  logic                           par_q, par_d;
  logic [TO_W-1:0]                to_cnt_q, to_cnt_d;
  logic [FRAME_DATA_BITS-1:0]     code_q, code_d;
  logic                           valid_q, valid_d;
  logic                           perr_q, perr_d;
  logic                           ferr_q, ferr_d;
  logic                           ovr_q, ovr_d;
  logic                           deliver;
  logic                           load;

  always_ff @(posedge sysClk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    par_d     = par_q;
    to_cnt_d  = '0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    deliver   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fall) begin
          if (!data_lvl) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (fall) begin
          sh_d = {data_lvl, sh_q[FRAME_DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = PARITY;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = data_lvl;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (!data_lvl)               ferr_d  = 1'b1;
          else if (!(^{sh_q, par_q}))  perr_d  = 1'b1;
          else                         deliver = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Inter-fall watchdog, only armed while a frame is in progress.
    if (state_q != IDLE && !fall) begin
      if (to_cnt_q == TO_LAST) begin
        ferr_d   = 1'b1;
        state_d  = IDLE;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  // A byte may land in the same cycle the consumer drains the old one.
  assign load  = deliver & (~valid_q | codeReady);
  assign ovr_d = deliver & valid_q & ~codeReady;

  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    if (load) begin
      code_d  = sh_q;
      valid_d = 1'b1;
    end else if (valid_q && codeReady) begin
      valid_d = 1'b0;
    end
  end

  assign code      = code_q;
  assign codeValid = valid_q;
  assign parityErr = perr_q;
  assign frameErr  = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_key_frame_rx.sv
// Directed bench for key_frame_rx: good, faulty, timed-out, overrun
// and reset-interrupted frames with hand-computed expectations.
module tb_key_frame_rx;

  localparam int T    = 64;
  localparam int HALF = 8;

  logic       sysClk = 1'b0;
  logic       reset = 1'b1;
  logic       keyClk = 1'b1;
  logic       keyData = 1'b1;
  logic       codeReady = 1'b0;
  logic [7:0] code;
  logic       codeValid, parityErr, frameErr, overrun, busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_pe = 0, n_fe = 0, n_ov = 0;
  int ferr_cyc = 0;
  int fall_cyc = 0;
  int pe0, fe0, ov0;

  key_frame_rx #(.TIMEOUT_CYCLES(T)) dut (
    .sysClk   (sysClk),
    .reset    (reset),
    .keyClk   (keyClk),
    .keyData  (keyData),
    .code     (code),
    .codeValid(codeValid),
    .codeReady(codeReady),
    .parityErr(parityErr),
    .frameErr (frameErr),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 sysClk = ~sysClk;

  always @(posedge sysClk) cyc <= cyc + 1;

  // Pulses last one full cycle, so one sample per negedge counts each once.
  always @(negedge sysClk) begin
    if (parityErr) n_pe++;
    if (frameErr) begin
      n_fe++;
      ferr_cyc = cyc;
    end
    if (overrun) n_ov++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    pe0 = n_pe;
    fe0 = n_fe;
    ov0 = n_ov;
  endtask

  task automatic send_bit(input logic b);
    @(negedge sysClk);
    keyData = b;
    repeat (HALF) @(negedge sysClk);
    keyClk   = 1'b0;
    fall_cyc = cyc;
    repeat (HALF) @(negedge sysClk);
    keyClk = 1'b1;
  endtask

  task automatic send_head(input logic [7:0] d, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_head(d, par);
    send_bit(stop);
    repeat (4) @(negedge sysClk);
    keyData = 1'b1;
  endtask

  task automatic accept();
    @(negedge sysClk);
    codeReady = 1'b1;
    @(negedge sysClk);
    codeReady = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge sysClk);
    check("rst_code", code, 0);
    check("rst_valid", codeValid, 0);
    check("rst_busy", busy, 0);
    check("rst_errs", {parityErr, frameErr, overrun}, 0);
    reset = 1'b0;
    repeat (4) @(negedge sysClk);

    // Good 0x1C held until accepted.
    snap();
    send_frame(8'h1C, 1'b0, 1'b1);
    check("good_code", code, 8'h1C);
    check("good_valid", codeValid, 1);
    check("good_busy", busy, 0);
    repeat (10) @(negedge sysClk);
    check("good_hold", codeValid, 1);
    accept();
    check("good_drain", codeValid, 0);
    check("good_keep_code", code, 8'h1C);
    check("good_no_err", (n_pe - pe0) + (n_fe - fe0) + (n_ov - ov0), 0);

    // Parity fault.
    snap();
    send_frame(8'h1C, 1'b1, 1'b1);
    check("par_pe", n_pe - pe0, 1);
    check("par_fe", n_fe - fe0, 0);
    check("par_valid", codeValid, 0);
    check("par_busy", busy, 0);

    // Stop-bit fault: frame error wins, no parity pulse.
    snap();
    send_frame(8'h1C, 1'b0, 1'b0);
    keyData = 1'b1;
    check("stop_fe", n_fe - fe0, 1);
    check("stop_pe", n_pe - pe0, 0);
    check("stop_valid", codeValid, 0);

    // Timeout after 4 data bits.
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("to_busy_mid", busy, 1);
    repeat (T + 20) @(negedge sysClk);
    check("to_fe", n_fe - fe0, 1);
    // Raw low seen at edge fall_cyc+1, FSM acts at +3, error T-1 edges later.
    check("to_latency", ferr_cyc - fall_cyc, T + 2);
    check("to_idle", busy, 0);
    check("to_valid", codeValid, 0);
    snap();
    send_frame(8'hF0, 1'b1, 1'b1);
    check("f0_code", code, 8'hF0);
    check("f0_valid", codeValid, 1);
    check("f0_no_err", (n_pe - pe0) + (n_fe - fe0), 0);
    accept();

    // Overrun: second byte dropped while first unconsumed.
    snap();
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h32, 1'b0, 1'b1);
    check("ovr_code", code, 8'h1C);
    check("ovr_valid", codeValid, 1);
    check("ovr_pulse", n_ov - ov0, 1);

    // Accept coincides with delivery of 0x29.
    snap();
    send_head(8'h29, 1'b0);
    @(negedge sysClk);
    keyData = 1'b1;
    repeat (HALF) @(negedge sysClk);
    keyClk = 1'b0;
    repeat (2) @(negedge sysClk);
    codeReady = 1'b1;
    @(negedge sysClk);
    codeReady = 1'b0;
    check("sim_code", code, 8'h29);
    check("sim_valid", codeValid, 1);
    repeat (HALF - 3) @(negedge sysClk);
    keyClk = 1'b1;
    repeat (4) @(negedge sysClk);
    check("sim_no_ovr", n_ov - ov0, 0);

    // Reset mid-frame with 0x29 still pending.
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    check("mr_busy", busy, 1);
    @(negedge sysClk);
    reset = 1'b1;
    @(negedge sysClk);
    check("mr_code", code, 0);
    check("mr_valid", codeValid, 0);
    check("mr_busy0", busy, 0);
    check("mr_errs", {parityErr, frameErr, overrun}, 0);
    reset   = 1'b0;
    keyData = 1'b1;
    repeat (4) @(negedge sysClk);
    snap();
    send_frame(8'h5A, 1'b1, 1'b1);
    check("5a_code", code, 8'h5A);
    check("5a_valid", codeValid, 1);
    check("5a_no_err", (n_pe - pe0) + (n_fe - fe0) + (n_ov - ov0), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
